// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per CALC cycle.
// Ports: clock, reset (sync, high), start, multiplicand, multiplier ->
//        product (held result), done (1-cycle pulse), busy (CALC/DONE).
// Optional feature macro: SEQ_MULTIPLIER_SIGNED_EN (two's complement operands).
module seq_multiplier #(
  parameter int MCAND_WIDTH  = 32,
  parameter int MPLIER_WIDTH = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [MCAND_WIDTH-1:0]              multiplicand,
  input  logic [MPLIER_WIDTH-1:0]             multiplier,
  output logic [MCAND_WIDTH+MPLIER_WIDTH-1:0] product,
  output logic                                done,
  output logic                                busy
);

  localparam int PW = MCAND_WIDTH + MPLIER_WIDTH;
  localparam int CW = $clog2(MPLIER_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]           mcand_q;
  logic [MPLIER_WIDTH-1:0] mplier_q;
  logic [PW-1:0]           acc_q;
  logic [CW-1:0]           count_q;

  logic [MCAND_WIDTH-1:0]  a_mag;
  logic [MPLIER_WIDTH-1:0] b_mag;
  logic [PW-1:0]           sum;
  logic [PW-1:0]           result;
  logic                    zero_op;
  logic                    last;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic neg_q;
  logic neg_d;

  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude 2^(W-1).
  always_comb begin
    a_mag = multiplicand[MCAND_WIDTH-1] ? -multiplicand : multiplicand;
    b_mag = multiplier[MPLIER_WIDTH-1] ? -multiplier : multiplier;
    neg_d = multiplicand[MCAND_WIDTH-1] ^ multiplier[MPLIER_WIDTH-1];
  end
`else
  always_comb begin
    a_mag = multiplicand;
    b_mag = multiplier;
  end
`endif

  always_comb begin
    zero_op = (multiplicand == '0) || (multiplier == '0);
    last    = (count_q == CW'(1));
    sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    result  = neg_q ? -sum : sum;
`else
    result  = sum;
`endif
  end

  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
        if (start)
          state_d = zero_op ? DONE_S : CALC;
      end
      CALC:    state_d = last ? DONE_S : CALC;
      DONE_S:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      product  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (zero_op) begin
              product <= '0;
            end else begin
              mcand_q  <= {{MPLIER_WIDTH{1'b0}}, a_mag};
              mplier_q <= b_mag;
              acc_q    <= '0;
              count_q  <= CW'(MPLIER_WIDTH);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
              neg_q    <= neg_d;
`endif
            end
          end
        end
        CALC: begin
          acc_q    <= sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q - CW'(1);
          if (last)
            product <= result;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done = (state_q == DONE_S);
    busy = (state_q != IDLE);
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier (default 32x32 parameters).
// Expected values are hand-computed for the active build.
module tb_seq_multiplier;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] product;
  logic        done;
  logic        busy;

  int checks;
  int errors;

  seq_multiplier #(
    .MCAND_WIDTH (32),
    .MPLIER_WIDTH(32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .product     (product),
    .done        (done),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL reset_product got %h want 0", product);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Start one operation and watch up to 45 cycles after acceptance.
  task automatic test_mult(input string name, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int lat);
    int done_at;
    int done_cnt;
    int busy_bad;
    done_at = -1;
    done_cnt = 0;
    busy_bad = 0;
    @(negedge clock);
    multiplicand = a;
    multiplier = b;
    start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (busy !== (k <= lat)) busy_bad++;
    end
    checks++;
    if (done_at != lat) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, done_at, lat);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_count got %0d want 1", name, done_cnt);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s_busy got %0d bad cycles want 0", name, busy_bad);
    end
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL %s_product got %h want %h", name, product, exp);
    end
  endtask

  task automatic test_ignore_start();
    int done_at;
    int done_cnt;
    done_at = -1;
    done_cnt = 0;
    @(negedge clock);
    multiplicand = 32'd6;
    multiplier = 32'd7;
    start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k == 10) begin
        start = 1'b1;
        multiplicand = 32'd100;
        multiplier = 32'd100;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    start = 1'b0;
    checks++;
    if (done_at != 33) begin
      errors++;
      $display("FAIL ignore_latency got %0d want 33", done_at);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_done_count got %0d want 1", done_cnt);
    end
    checks++;
    if (product !== 64'h2A) begin
      errors++;
      $display("FAIL ignore_product got %h want 2a", product);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    @(negedge clock);
    multiplicand = 32'd11;
    multiplier = 32'd13;
    start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (done === 1'b1) done_cnt++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_busy got %b want 0", busy);
    end
    checks++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL midreset_product got %h want 0", product);
    end
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clock);
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL midreset_no_done got %0d pulses want 0", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int d1;
    int d2;
    d1 = -1;
    d2 = -1;
    @(negedge clock);
    multiplicand = 32'd2;
    multiplier = 32'd3;
    start = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (k == 67) start = 1'b0;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    start = 1'b0;
    checks++;
    if (d1 != 33) begin
      errors++;
      $display("FAIL b2b_first got %0d want 33", d1);
    end
    checks++;
    if (d2 != 67) begin
      errors++;
      $display("FAIL b2b_second got %0d want 67", d2);
    end
    checks++;
    if (product !== 64'd6) begin
      errors++;
      $display("FAIL b2b_product got %h want 6", product);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult("m3x5", 32'd3, 32'd5, 64'hF, 33);
    test_mult("zero_a", 32'd0, 32'h12345678, 64'd0, 1);
    test_mult("m16x16", 32'h10000, 32'h10000, 64'h1_0000_0000, 33);
    test_mult("zero_b", 32'h1234, 32'd0, 64'd0, 1);
    test_mult("mffff", 32'hFFFF, 32'hFFFF, 64'hFFFE_0001, 33);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    test_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 33);
    test_mult("neg3x5", 32'hFFFF_FFFD, 32'd5,
              64'hFFFF_FFFF_FFFF_FFF1, 33);
    test_mult("min_x2", 32'h8000_0000, 32'd2,
              64'hFFFF_FFFF_0000_0000, 33);
    test_mult("m7xneg", 32'd7, 32'h8000_0001,
              64'hFFFF_FFFC_8000_0007, 33);
`else
    test_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFF_FFFE_0000_0001, 33);
    test_mult("neg3x5", 32'hFFFF_FFFD, 32'd5, 64'h4_FFFF_FFF1, 33);
    test_mult("min_x2", 32'h8000_0000, 32'd2, 64'h1_0000_0000, 33);
    test_mult("m7xneg", 32'd7, 32'h8000_0001, 64'h3_8000_0007, 33);
`endif
    test_ignore_start();
    test_reset_mid();
    test_mult("after_reset", 32'd9, 32'd9, 64'h51, 33);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter MCAND_WIDTH, default 32, giving the multiplicand width in bits.
REQ-002 The block SHALL have parameter MPLIER_WIDTH, default 32, giving the multiplier width and the iteration count.
REQ-003 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 The block SHALL have port multiplicand  input  MCAND_WIDTH  operand A; captured on accepted start.
REQ-007 The block SHALL have port multiplier  input  MPLIER_WIDTH  operand B; captured on accepted start.
REQ-008 The block SHALL have port product  output  MCAND_WIDTH+MPLIER_WIDTH  result register.
REQ-009 The block SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-010 The block SHALL have port busy  output  1  high in CALC and DONE; low in IDLE.

Function
REQ-011 The block SHALL implement states IDLE, CALC and DONE; undefined encodings go to IDLE.
REQ-012 In IDLE with start=1 and both operands nonzero, the block SHALL capture both operands, clear the accumulator, load the counter with MPLIER_WIDTH and go to CALC.
REQ-013 In IDLE with start=1 and either operand zero, the block SHALL load product with 0 and go directly to DONE (zero early-exit).
REQ-014 Each CALC cycle SHALL add the multiplicand, zero-extended to full product width and shifted by the current bit position, to the accumulator when the current multiplier LSB is 1, then shift the multiplier right by one and decrement the counter.
REQ-015 When CALC is entered with counter=1, the block SHALL write the final accumulator to product and go to DONE.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-017 Latency SHALL be: start accepted at cycle T -> done at T+MPLIER_WIDTH+1 (nonzero operands), T+1 (zero operand).
REQ-018 product SHALL hold its value from DONE until the next accepted start overwrites it; no overflow is possible (full-width result).
REQ-019 start SHALL be ignored in CALC and DONE; operand inputs changing after capture SHALL not affect the result.
REQ-020 start held high continuously SHALL start a new operation in the IDLE cycle after each DONE (one idle cycle between operations).

Reset
REQ-021 On reset=1 at a clock edge the block SHALL enter IDLE with product=0, accumulator=0, counter=0, done=0, busy=0.
REQ-022 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse; reset SHALL take priority over start.

Configuration
REQ-023 With macro SEQ_MULTIPLIER_SIGNED_EN defined, the block SHALL treat both operands as two's complement: capture magnitudes, run the unsigned CALC iteration unchanged, and negate the product in the transition to DONE when operand signs differ; latency SHALL be identical to unsigned.
REQ-024 Without SEQ_MULTIPLIER_SIGNED_EN, operands SHALL be unsigned and no sign logic SHALL be synthesized.

Verification (default parameters)
REQ-025 start with 3 x 5 at cycle T -> busy high T+1..T+33, done=1 only at T+33, product=0x000000000000000F.
REQ-026 start with 0xFFFFFFFF x 0xFFFFFFFF (unsigned build) -> product=0xFFFFFFFE00000001 at done.
REQ-027 start with 0 x 0x12345678 at T -> done at T+1, product=0.
REQ-028 start pulsed at T+10 during CALC with new operands -> ignored; first result unchanged, no extra done.
REQ-029 reset at T+15 mid-CALC -> IDLE next cycle, product=0, busy=0, no done; new start then completes normally.
REQ-030 SEQ_MULTIPLIER_SIGNED_EN build, 0xFFFFFFFD (-3) x 5 -> product=0xFFFFFFFFFFFFFFF1 (-15) at T+33.
